// File: rtl/shift_sub_divider_pkg.sv
// Shared definitions for the shift/subtract restoring divider.
package shift_sub_divider_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    SUB   = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/shift_sub_divider_sub.sv
// Trial subtraction for one restoring-division step: diff = r - d, with borrow out.
module div_sub_stage
  import shift_sub_divider_pkg::*;
#(
  parameter int unsigned width = DEFAULT_WIDTH
) (
  input  logic [width:0]   r,
  input  logic [width-1:0] d,
  output logic [width:0]   diff,
  output logic             borrow
);

  logic [width+1:0] full;

  // One extra bit above r so the sign of the result is the borrow.
  assign full   = {1'b0, r} - {2'b00, d};
  assign diff   = full[width:0];
  assign borrow = full[width+1];

endmodule

// File: rtl/shift_sub_divider.sv
// Sequential unsigned restoring divider: one SHIFT and one SUB cycle per quotient bit.
module shift_sub_divider
  import shift_sub_divider_pkg::*;
#(
  parameter int unsigned width = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Begin,
  input  logic [width-1:0] Dividend,
  input  logic [width-1:0] Divisor,
  output logic             Busy,
  output logic             End,
  output logic             DivByZero,
  output logic [width-1:0] Quotient,
  output logic [width-1:0] Remainder
);

  localparam int unsigned CW = $clog2(width) + 1;
  localparam logic [CW-1:0] LAST = CW'(width - 1);

  state_t           state, state_next;
  logic [width:0]   r;
  logic [width-1:0] q, d;
  logic [CW-1:0]    cnt;
  logic [width:0]   diff;
  logic             borrow;

  div_sub_stage #(.width(width)) u_sub (
    .r      (r),
    .d      (d),
    .diff   (diff),
    .borrow (borrow)
  );

  assign Busy = (state == SHIFT) || (state == SUB);
  assign End  = (state == DONE);

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (Begin) state_next = (Divisor == '0) ? DONE : SHIFT;
      SHIFT:      state_next = SUB;
      SUB:        state_next = (cnt == LAST) ? DONE : SHIFT;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r         <= '0;
      q         <= '0;
      d         <= '0;
      cnt       <= '0;
      Quotient  <= '0;
      Remainder <= '0;
      DivByZero <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (Begin) begin
            q   <= Dividend;
            d   <= Divisor;
            r   <= '0;
            cnt <= '0;
            if (Divisor == '0) begin
              DivByZero <= 1'b1;
              Quotient  <= '1;
              Remainder <= Dividend;
            end
          end
        end
        SHIFT: {r, q} <= {r[width-1:0], q, 1'b0};
        SUB: begin
          if (!borrow) r <= diff;
          q[0] <= ~borrow;
          cnt  <= cnt + 1'b1;
          // Results are taken from the values being written this cycle.
          if (cnt == LAST) begin
            Quotient  <= {q[width-1:1], ~borrow};
            Remainder <= borrow ? r[width-1:0] : diff[width-1:0];
            DivByZero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sub_divider.sv
// Directed bench for shift_sub_divider with a cycle-level arithmetic reference model.
module tb_shift_sub_divider;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend, divisor;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int tests = 0;
  int fails = 0;
  bit checking = 0;

  shift_sub_divider #(.width(W)) dut (
    .CLK       (clk),
    .RST       (rst),
    .Begin     (start),
    .Dividend  (dividend),
    .Divisor   (divisor),
    .Busy      (busy),
    .End       (done),
    .DivByZero (div_by_zero),
    .Quotient  (quotient),
    .Remainder (remainder)
  );

  always #5 clk = ~clk;

  // Reference: an accepted start schedules the result 2*W edges later,
  // computed directly with / and %.
  bit           m_busy, m_done, m_dz;
  logic [W-1:0] m_q, m_r, p_q, p_r;
  int           m_left;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_done = 0; m_dz = 0; m_q = '0; m_r = '0; m_left = 0;
    end else if (start && !m_busy) begin
      if (divisor == '0) begin
        m_busy = 0; m_done = 1; m_dz = 1; m_q = '1; m_r = dividend;
      end else begin
        m_busy = 1; m_done = 0; m_left = 2 * W;
        p_q = dividend / divisor;
        p_r = dividend % divisor;
      end
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 0; m_done = 1; m_dz = 0; m_q = p_q; m_r = p_r;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      check("busy", 32'(busy), 32'(m_busy));
      check("end", 32'(done), 32'(m_done));
      check("busy_end_excl", 32'(busy & done), 32'd0);
      check("div_by_zero", 32'(div_by_zero), 32'(m_dz));
      check("quotient", 32'(quotient), 32'(m_q));
      check("remainder", 32'(remainder), 32'(m_r));
    end
  end

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!done) check("end_timeout", 32'(done), 32'd1);
  endtask

  // Latency is counted in cycles after the edge that samples Begin.
  task automatic run_op(input logic [W-1:0] dd, input logic [W-1:0] dv, input int exp_lat,
                        input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz);
    int n;
    start = 1'b1; dividend = dd; divisor = dv;
    @(negedge clk);
    start = 1'b0; dividend = '1; divisor = '1;
    if (exp_lat != 0) check("end_drops", 32'(done), 32'd0);
    wait_done(n);
    check("latency", 32'(n), 32'(exp_lat));
    check("lit_q", 32'(quotient), 32'(eq));
    check("lit_r", 32'(remainder), 32'(er));
    check("lit_dz", 32'(div_by_zero), 32'(edz));
    check("model_q", 32'(m_q), 32'(eq));
    check("model_r", 32'(m_r), 32'(er));
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    checking = 1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_end", 32'(done), 32'd0);
    check("rst_q", 32'(quotient), 32'd0);
    check("rst_r", 32'(remainder), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op(16'd100, 16'd7, 32, 16'd14, 16'd2, 1'b0);
    run_op(16'hFFFF, 16'h0001, 32, 16'hFFFF, 16'h0000, 1'b0);
    run_op(16'd3, 16'd10, 32, 16'd0, 16'd3, 1'b0);
    run_op(16'hFFFF, 16'hFFFF, 32, 16'h0001, 16'h0000, 1'b0);
    run_op(16'd5, 16'd0, 0, 16'hFFFF, 16'd5, 1'b1);

    // Begin while busy must be ignored.
    start = 1'b1; dividend = 16'd1000; divisor = 16'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    start = 1'b1; dividend = 16'd50; divisor = 16'd5;
    @(negedge clk);
    start = 1'b0; dividend = '0; divisor = '0;
    wait_done(n);
    check("busy_begin_latency", 32'(n), 32'd22);
    check("busy_begin_q", 32'(quotient), 32'd111);
    check("busy_begin_r", 32'(remainder), 32'd1);

    // Reset in the middle of an operation.
    start = 1'b1; dividend = 16'd255; divisor = 16'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_end", 32'(done), 32'd0);
    check("midrst_q", 32'(quotient), 32'd0);
    check("midrst_r", 32'(remainder), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    run_op(16'd81, 16'd9, 32, 16'd9, 16'd0, 1'b0);

    // Restart on the same cycle End is first observed.
    run_op(16'd77, 16'd8, 32, 16'd9, 16'd5, 1'b0);

    repeat (3) @(negedge clk);
    checking = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
